adder_1_checker: RTL and testbench
==================================

# adder_1_checker

On-chip response checker for the 1-bit full adder: the consuming end of the adder's stimulus/response interface. It samples each applied vector {a, b, cin} together with the adder's {s, cout}. It compares the adder outputs against the golden full-adder function, then counts vectors and mismatches over a run of N_VECTORS. At the end of the run it reports pass/fail and the first failing vector, through a start/busy/done handshake.

## Interface
- N_VECTORS, 256, number of valid vectors checked per run; legal range 1 .. 2^CNT_W-1
- CNT_W, 16, width of all counters and of first_err_vec
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  run request; sampled in IDLE and DONE only
- valid  input  1  a/b/cin/s/cout carry a vector this cycle
- a, b, cin  input  1 each  operands applied to the adder
- s, cout  input  1 each  adder outputs for that vector
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE
- pass  output  1  valid only while done=1; 1 iff err_cnt==0
- vec_cnt  output  CNT_W  vectors accepted in the current/last run
- err_cnt  output  CNT_W  mismatching vectors; saturates at all-ones
- first_err_vec  output  CNT_W  0-based index of the first mismatching vector
- first_err_bits  output  5  {a,b,cin,s,cout} of the first mismatching vector
- first_err_vld  output  1  first_err_* holds a captured error

## Operation
- Golden model: s_exp = a^b^cin; cout_exp = (a&b)|(a&cin)|(b&cin). A vector is a mismatch if s!=s_exp or cout!=cout_exp.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: busy=0, done=0.
  - start=1 → RUN.
  - On that edge, clear vec_cnt, err_cnt, first_err_vec, first_err_bits and first_err_vld.
- RUN: a cycle with valid=1 is an accepted vector.
  - vec_cnt increments on the accepting edge.
  - Stage-1 registers capture the vector, the mismatch flag and the vector index (the old vec_cnt).
  - The edge that accepts vector N_VECTORS-1 (the N-th vector) moves RUN → DRAIN.
  - valid=0 cycles are ignored and do not advance vec_cnt.
- DRAIN: lasts exactly one cycle; valid is ignored. → DONE.
- DONE: done=1 and pass is driven. All counters hold until start=1, which behaves as in IDLE (clear + RUN).
- Error update (stage 2): one edge after acceptance, if the stage-1 mismatch flag is set:
  - err_cnt increments unless it is already all-ones.
  - If first_err_vld=0, capture the index into first_err_vec and the bits into first_err_bits, and set first_err_vld.
- start in RUN/DRAIN: ignored.
- valid in IDLE/DONE: ignored.

## Timing
- Reset (async, immediate): state=IDLE; busy, done, pass, first_err_vld = 0; all counters and captured fields = 0. Stage-1 valid is cleared.
- Reset asserted mid-run aborts the run. The in-flight stage-1 vector is discarded and no count is updated.
- start edge E0: busy=1 from E0.
- Vector sampled at edge E:
  - vec_cnt reflects it after E.
  - err_cnt and first_err_* reflect it after E+1.
- Last (N-th) vector accepted at edge E:
  - state is DRAIN after E.
  - At E+1 its error update completes and the state becomes DONE, simultaneously.
  - From E+1: done=1, busy=0, counters final, pass valid.
- Back-to-back valid every cycle: a run completes in N_VECTORS+1 cycles after the start edge.
- Restart from DONE at edge E: done=0 and busy=1 after E; counters cleared on the same edge.

## Test plan
- N_VECTORS=8, start, then all 8 {a,b,cin} combinations with correct s/cout on consecutive cycles.
  - Expect: done rises 9 edges after start, pass=1, vec_cnt=8, err_cnt=0, first_err_vld=0.
- N_VECTORS=8, vector index 3 is a=1, b=1, cin=0, s=1, cout=1 (s wrong); all others correct.
  - Expect: err_cnt=1, first_err_vec=3, first_err_bits=5'b11011, first_err_vld=1, pass=0.
- N_VECTORS=4, valid pattern 1,0,0,1,1,0,1, with vectors 1 and 3 wrong.
  - Expect: vec_cnt=4, err_cnt=2, first_err_vec=1.
  - Expect: done exactly one edge after the 4th valid cycle.
- start pulsed mid-RUN → ignored: counts continue unchanged. Then start in DONE → done=0, busy=1, counters zeroed on that edge.
- Assert rst after 3 of 8 vectors, with vector 2 erroneous and still in stage 1.
  - Expect: all outputs 0 immediately and state IDLE.
  - Expect: a new start/run of 8 correct vectors gives pass=1.
- CNT_W=4, N_VECTORS=15, every vector wrong.
  - Expect: err_cnt=15 (all-ones, held, no wrap), first_err_vec=0, pass=0.

Source files
------------

// File: rtl/adder_1_checker.sv
// Response checker for a 1-bit full adder: compares each applied vector against
// the golden function, counts vectors/mismatches per run and reports the first failure.
module adder_1_checker #(
   parameter int N_VECTORS = 256,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             valid,
   input  logic             a,
   input  logic             b,
   input  logic             cin,
   input  logic             s,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_vec,
   output logic [4:0]       first_err_bits,
   output logic             first_err_vld
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);
   localparam logic [CNT_W-1:0] ALL_ONES = '1;

   logic [1:0]       state;
   logic             s_exp, cout_exp, mis, accept, launch;
   logic             s1_vld, s1_mis;
   logic [CNT_W-1:0] s1_idx;
   logic [4:0]       s1_bits;

   always_comb begin
      s_exp    = a ^ b ^ cin;
      cout_exp = (a & b) | (a & cin) | (b & cin);
      mis      = (s != s_exp) || (cout != cout_exp);
      accept   = (state == RUN) && valid;
      launch   = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (accept && (vec_cnt == LAST_IDX)) state <= DRAIN;
            DRAIN:   state <= DONE;
            DONE:    if (start) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage 1: register the vector with its verdict and its 0-based index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_mis  <= 1'b0;
         s1_idx  <= '0;
         s1_bits <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_mis  <= mis;
            s1_idx  <= vec_cnt;
            s1_bits <= {a, b, cin, s, cout};
         end
      end
   end

   // Stage 2 completes on the DRAIN edge for the last vector, so counts are final in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt        <= '0;
         err_cnt        <= '0;
         first_err_vec  <= '0;
         first_err_bits <= '0;
         first_err_vld  <= 1'b0;
      end else if (launch) begin
         vec_cnt        <= '0;
         err_cnt        <= '0;
         first_err_vec  <= '0;
         first_err_bits <= '0;
         first_err_vld  <= 1'b0;
      end else begin
         if (accept) vec_cnt <= vec_cnt + CNT_W'(1);
         if (s1_vld && s1_mis) begin
            if (err_cnt != ALL_ONES) err_cnt <= err_cnt + CNT_W'(1);
            if (!first_err_vld) begin
               first_err_vec  <= s1_idx;
               first_err_bits <= s1_bits;
               first_err_vld  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
      pass = done && (err_cnt == '0);
   end

endmodule

// File: tb/tb_adder_1_checker.sv
// Scoreboard bench: three checker instances (N=8, N=4, CNT_W=4/N=15) share the vector bus;
// expected run summaries are queued at start and popped when done rises.
module tb_adder_1_checker;

   typedef struct {
      logic [2:0] abc;
      bit         flip_s;
      bit         flip_c;
      int         gap;
      bit         st;
   } vec_t;

   typedef struct {
      int          dut;
      int          vcnt;
      int          ecnt;
      int          fvec;
      logic [4:0]  fbits;
      bit          fvld;
      bit          pas;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic valid, a, b, cin, s, cout;
   logic [2:0] start, busy, done, pass, fvld;
   logic [15:0] vc[3], ec[3], fev[3];
   logic [4:0]  feb[3];
   logic [15:0] vc0, ec0, fev0, vc1, ec1, fev1;
   logic [3:0]  vc2, ec2, fev2;
   logic [4:0]  feb0, feb1, feb2;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   vec_t vq[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_1_checker #(.N_VECTORS(8), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .valid(valid), .a(a), .b(b), .cin(cin),
      .s(s), .cout(cout), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .vec_cnt(vc0),
      .err_cnt(ec0), .first_err_vec(fev0), .first_err_bits(feb0), .first_err_vld(fvld[0]));
   adder_1_checker #(.N_VECTORS(4), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .valid(valid), .a(a), .b(b), .cin(cin),
      .s(s), .cout(cout), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .vec_cnt(vc1),
      .err_cnt(ec1), .first_err_vec(fev1), .first_err_bits(feb1), .first_err_vld(fvld[1]));
   adder_1_checker #(.N_VECTORS(15), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .valid(valid), .a(a), .b(b), .cin(cin),
      .s(s), .cout(cout), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .vec_cnt(vc2),
      .err_cnt(ec2), .first_err_vec(fev2), .first_err_bits(feb2), .first_err_vld(fvld[2]));

   assign vc[0] = vc0;           assign vc[1] = vc1;           assign vc[2] = {12'd0, vc2};
   assign ec[0] = ec0;           assign ec[1] = ec1;           assign ec[2] = {12'd0, ec2};
   assign fev[0] = fev0;         assign fev[1] = fev1;         assign fev[2] = {12'd0, fev2};
   assign feb[0] = feb0;         assign feb[1] = feb1;         assign feb[2] = feb2;

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic chk_zero(input int d, input string tag);
      chk({tag, " busy"}, busy[d], 0);
      chk({tag, " done"}, done[d], 0);
      chk({tag, " pass"}, pass[d], 0);
      chk({tag, " vec_cnt"}, vc[d], 0);
      chk({tag, " err_cnt"}, ec[d], 0);
      chk({tag, " first_err_vec"}, fev[d], 0);
      chk({tag, " first_err_bits"}, feb[d], 0);
      chk({tag, " first_err_vld"}, fvld[d], 0);
   endtask

   // Monitor: every rising done is matched against the oldest expected summary
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (done[i] && !busy[i] && (exp_q.size() != 0) && (exp_q[0].dut == i) &&
             (exp_q[0].done_cyc <= cyc)) begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("vec_cnt", vc[i], e.vcnt);
            chk("err_cnt", ec[i], e.ecnt);
            chk("first_err_vec", fev[i], e.fvec);
            chk("first_err_bits", feb[i], e.fbits);
            chk("first_err_vld", fvld[i], e.fvld);
            chk("pass", pass[i], e.pas);
         end
      end
   end

   // Drive vq into DUT d; abort asserts rst after the last driven vector
   task automatic run(input int d, input int nv, input bit abort);
      exp_t e;
      int   sum, gaps, errs, cw, sc;
      logic gs, gc;
      cw = (d == 2) ? 4 : 16;
      gaps = 0; errs = 0;
      e.dut = d; e.fvec = 0; e.fbits = '0; e.fvld = 0;
      for (int k = 0; k < vq.size(); k++) begin
         sum = int'(vq[k].abc[2]) + int'(vq[k].abc[1]) + int'(vq[k].abc[0]);
         gs = logic'(sum % 2) ^ vq[k].flip_s;
         gc = logic'(sum / 2) ^ vq[k].flip_c;
         gaps += vq[k].gap;
         if (vq[k].flip_s || vq[k].flip_c) begin
            if (errs == 0) begin
               e.fvec = k; e.fbits = {vq[k].abc, gs, gc}; e.fvld = 1;
            end
            errs++;
         end
      end
      sc = (1 << cw) - 1;
      e.vcnt = nv;
      e.ecnt = (errs > sc) ? sc : errs;
      e.pas  = (errs == 0);

      @(posedge clk); #1;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      e.done_cyc = cyc + gaps + nv + 1;
      chk("start busy", busy[d], 1);
      chk("start done", done[d], 0);
      chk("start vec_cnt", vc[d], 0);
      chk("start err_cnt", ec[d], 0);
      chk("start first_err_vld", fvld[d], 0);
      if (!abort) exp_q.push_back(e);

      for (int k = 0; k < vq.size(); k++) begin
         repeat (vq[k].gap) begin @(posedge clk); #1; end
         sum = int'(vq[k].abc[2]) + int'(vq[k].abc[1]) + int'(vq[k].abc[0]);
         {a, b, cin} = vq[k].abc;
         s    = logic'(sum % 2) ^ vq[k].flip_s;
         cout = logic'(sum / 2) ^ vq[k].flip_c;
         valid = 1'b1;
         start[d] = vq[k].st;
         @(posedge clk); #1;
         valid = 1'b0;
         start[d] = 1'b0;
         chk("running vec_cnt", vc[d], k + 1);
      end

      if (abort) begin
         rst = 1'b1;
         #1;
         chk_zero(d, "abort");
         @(posedge clk); #1;
         rst = 1'b0;
      end else begin
         repeat (3) @(negedge clk);
         chk("done seen", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic add(input logic [2:0] abc, input bit fs, input bit fc, input int gap, input bit st);
      vec_t v;
      v.abc = abc; v.flip_s = fs; v.flip_c = fc; v.gap = gap; v.st = st;
      vq.push_back(v);
   endtask

   task automatic add_rand(input int n, input int err_pct, input bit gaps);
      bit fs, fc;
      for (int k = 0; k < n; k++) begin
         fs = ($urandom_range(99) < err_pct);
         fc = fs ? 1'($urandom_range(1)) : ($urandom_range(99) < err_pct);
         add(3'($urandom_range(7)), fs, fc, gaps ? int'($urandom_range(2)) : 0,
             ($urandom_range(7) == 0));
      end
   endtask

   initial begin
      rst = 1'b1; start = '0; valid = 0; a = 0; b = 0; cin = 0; s = 0; cout = 0;
      #1;
      for (int d = 0; d < 3; d++) chk_zero(d, "reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // all eight combinations, all correct
      vq.delete();
      for (int k = 0; k < 8; k++) add(3'(k), 0, 0, 0, 0);
      run(0, 8, 0);

      // index 3 = 110 with s wrong; a start pulse mid-run must be ignored
      vq.delete();
      for (int k = 0; k < 8; k++) add((k == 3) ? 3'b110 : (k == 6) ? 3'b011 : 3'(k), k == 3, 0, 0, k == 5);
      run(0, 8, 0);

      // N=4 with valid pattern 1,0,0,1,1,0,1 and vectors 1 and 3 wrong
      vq.delete();
      add(3'b001, 0, 0, 0, 0); add(3'b101, 0, 1, 2, 0);
      add(3'b111, 0, 0, 0, 0); add(3'b010, 1, 0, 1, 0);
      run(1, 4, 0);

      // reset with erroneous vector 2 still in stage 1, then a clean run
      vq.delete();
      add(3'b000, 0, 0, 0, 0); add(3'b011, 0, 0, 0, 0); add(3'b110, 1, 0, 0, 0);
      run(0, 8, 1);
      vq.delete();
      add_rand(8, 0, 0);
      run(0, 8, 0);

      // 4-bit counters, every vector wrong: err_cnt saturates at 15
      vq.delete();
      for (int k = 0; k < 15; k++) add(3'($urandom_range(7)), 1, 1'($urandom_range(1)), 0, 0);
      run(2, 15, 0);

      // randomized runs
      for (int r = 0; r < 8; r++) begin
         vq.delete();
         case (r % 3)
            0: begin add_rand(8, 20, 1);  run(0, 8, 0);  end
            1: begin add_rand(4, 30, 1);  run(1, 4, 0);  end
            default: begin add_rand(15, 60, 1); run(2, 15, 0); end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
